// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: one-op-at-a-time micro-op sequencer for the 4x16
// dual-read / single-write register file. Each accepted op walks
// IDLE -> READ -> EXEC -> WB -> IDLE; every output comes straight from a flop.
// Optional feature macro: REGFILE_SEQ_FLAGS_EN adds zero/carry flag outputs.
module regfile_op_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic [DATA_W-1:0] op_imm,
    output logic [ADDR_W-1:0] rdAddrA,
    input  logic [DATA_W-1:0] rdDataA,
    output logic [ADDR_W-1:0] rdAddrB,
    input  logic [DATA_W-1:0] rdDataB,
    output logic              write,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    localparam logic [ADDR_W-1:0] NUM_REGS_C = ADDR_W'(NUM_REGS);

    state_t              state_q, state_d;
    logic [2:0]          code_q;
    logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]   imm_q, opa_q, opb_q, result_q;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                accept_s;
    logic                illegal_s;
    logic [DATA_W-1:0]   alu_s;

    assign accept_s = op_valid & ready_q & (state_q == S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed four-step walk once an op is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  begin
                if (accept_s) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address legality of the captured op; NOP never faults, LDI only checks rd.
    always_comb begin
        illegal_s = 1'b0;
        case (code_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                illegal_s = (rd_q >= NUM_REGS_C) | (rs1_q >= NUM_REGS_C) | (rs2_q >= NUM_REGS_C);
            OP_MOV:  illegal_s = (rd_q >= NUM_REGS_C) | (rs1_q >= NUM_REGS_C);
            OP_LDI:  illegal_s = (rd_q >= NUM_REGS_C);
            default: illegal_s = 1'b0;
        endcase
    end

    // Execute-stage datapath: modulo arithmetic and bitwise logic on the operands.
    always_comb begin
        alu_s = {DATA_W{1'b0}};
        case (code_q)
            OP_ADD:  alu_s = opa_q + opb_q;
            OP_SUB:  alu_s = opa_q - opb_q;
            OP_AND:  alu_s = opa_q & opb_q;
            OP_OR:   alu_s = opa_q | opb_q;
            OP_XOR:  alu_s = opa_q ^ opb_q;
            OP_LDI:  alu_s = imm_q;
            OP_MOV:  alu_s = opa_q;
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the transition.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_EXEC);
        err_d   = (state_q == S_EXEC) & illegal_s;
        write_d = (state_q == S_EXEC) & ~illegal_s & (code_q != OP_NOP);
        if (accept_s) begin
            rd_addr_a_d = op_rs1;
            rd_addr_b_d = op_rs2;
        end else begin
            rd_addr_a_d = rd_addr_a_q;
            rd_addr_b_d = rd_addr_b_q;
        end
        if (state_q == S_EXEC) begin
            wr_addr_d = rd_q;
        end else begin
            wr_addr_d = wr_addr_q;
        end
    end

    // Output registers so every port is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            write_q     <= 1'b0;
            rd_addr_a_q <= {ADDR_W{1'b0}};
            rd_addr_b_q <= {ADDR_W{1'b0}};
            wr_addr_q   <= {ADDR_W{1'b0}};
        end else begin
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            write_q     <= write_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    // Op capture, operand latch in READ and result register in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= 3'd0;
            rd_q     <= {ADDR_W{1'b0}};
            rs1_q    <= {ADDR_W{1'b0}};
            rs2_q    <= {ADDR_W{1'b0}};
            imm_q    <= {DATA_W{1'b0}};
            opa_q    <= {DATA_W{1'b0}};
            opb_q    <= {DATA_W{1'b0}};
            result_q <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                code_q <= op_code;
                rd_q   <= op_rd;
                rs1_q  <= op_rs1;
                rs2_q  <= op_rs2;
                imm_q  <= op_imm;
            end
            if (state_q == S_READ) begin
                opa_q <= rdDataA;
                opb_q <= rdDataB;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_s;
            end
        end
    end

`ifdef REGFILE_SEQ_FLAGS_EN
    logic          carry_s;
    logic          carry_q;
    logic          flag_z_q, flag_c_q;
    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    assign sum_s  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff_s = {1'b0, opa_q} - {1'b0, opb_q};

    // Carry for ADD, borrow for SUB, zero for everything else.
    always_comb begin
        carry_s = 1'b0;
        case (code_q)
            OP_ADD:  carry_s = sum_s[DATA_W];
            OP_SUB:  carry_s = diff_s[DATA_W];
            default: carry_s = 1'b0;
        endcase
    end

    // Flags update when leaving WB for non-faulting ALU ops only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (state_q == S_EXEC) begin
                carry_q <= carry_s;
            end
            if ((state_q == S_WB) && !err_q && (code_q <= OP_XOR)) begin
                flag_z_q <= (result_q == {DATA_W{1'b0}});
                flag_c_q <= carry_q;
            end
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

    assign op_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign write    = write_q;
    assign rdAddrA  = rd_addr_a_q;
    assign rdAddrB  = rd_addr_b_q;
    assign wrAddr   = wr_addr_q;
    assign wrData   = result_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer: directed ops push expected WB
// records; a negedge monitor pops one per done pulse. A small register file
// model sits behind the DUT's read/write ports.
module tb_regfile_op_sequencer;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [AW-1:0] op_rd, op_rs1, op_rs2;
    logic [DW-1:0] op_imm;
    logic [AW-1:0] rdAddrA, rdAddrB, wrAddr;
    logic [DW-1:0] rdDataA, rdDataB, wrData;
    logic          write, busy, done, err;

    regfile_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2),
        .op_imm(op_imm), .rdAddrA(rdAddrA), .rdDataA(rdDataA),
        .rdAddrB(rdAddrB), .rdDataB(rdDataB), .write(write), .wrAddr(wrAddr),
        .wrData(wrData), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: 4 registers, combinational read, write on clock edge.
    logic [DW-1:0] rf [0:3];
    logic          model_init_n;
    always @(posedge clk or negedge model_init_n) begin
        if (!model_init_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= 16'h0000;
        end else if (write && (wrAddr < 3'd4)) begin
            rf[wrAddr[1:0]] <= wrData;
        end
    end
    assign rdDataA = (rdAddrA < 3'd4) ? rf[rdAddrA[1:0]] : 16'hDEAD;
    assign rdDataB = (rdAddrB < 3'd4) ? rf[rdAddrB[1:0]] : 16'hDEAD;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          er;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int tests = 0, fails = 0;
    int m_tests = 0, m_fails = 0;

    // Monitor: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            m_tests++;
            if (q.size() == 0) begin
                m_fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc + 2) begin
                    m_fails++;
                    $display("FAIL done_latency: got cycle %0d, required %0d", cyc, mon_e.cyc + 2);
                end
                m_tests++;
                if (write !== mon_e.wr) begin
                    m_fails++;
                    $display("FAIL wb_write: got %0b, required %0b", write, mon_e.wr);
                end
                m_tests++;
                if (err !== mon_e.er) begin
                    m_fails++;
                    $display("FAIL wb_err: got %0b, required %0b", err, mon_e.er);
                end
                if (mon_e.wr) begin
                    m_tests++;
                    if (wrAddr !== mon_e.addr || wrData !== mon_e.data) begin
                        m_fails++;
                        $display("FAIL wb_data: got addr %0d data %h, required addr %0d data %h",
                                 wrAddr, wrData, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    // Offer one op, wait (bounded) for acceptance, then queue its expected WB.
    task automatic send(input logic [2:0] c, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [DW-1:0] imm,
                        input logic ewr, input logic eer, input logic [DW-1:0] edata,
                        input bit hold, output int acc_cyc, output int nready0);
        logic r;
        op_code = c; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2; op_imm = imm;
        op_valid = 1'b1;
        acc_cyc = -1;
        nready0 = 0;
        for (int k = 0; k < 20 && acc_cyc < 0; k++) begin
            @(negedge clk);
            r = op_ready;
            if (!r) nready0++;
            @(posedge clk);
            #1;
            if (r) acc_cyc = cyc;
        end
        if (acc_cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept in 20 cycles, required accept");
        end else begin
            q.push_back('{wr: ewr, addr: rd, data: edata, er: eer, cyc: acc_cyc});
        end
        if (!hold) op_valid = 1'b0;
    endtask

    // Wait (bounded) for all queued ops to complete and their writes to land.
    task automatic wait_idle();
        for (int k = 0; k < 30 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    int a1, a2, n1, n2;

    initial begin
        rst_n = 1'b0; model_init_n = 1'b0; op_valid = 1'b0;
        op_code = 3'd7; op_rd = 3'd0; op_rs1 = 3'd0; op_rs2 = 3'd0; op_imm = 16'h0000;
        #1 model_init_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, op_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);
        chk("rst_write", {31'd0, write},    32'd0);
        chk("rst_addrs", {23'd0, rdAddrA, rdAddrB, wrAddr}, 32'd0);
        chk("rst_wrdata", {16'd0, wrData},  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LDI ignores out-of-range rs1/rs2.
        send(3'd5, 3'd2, 3'd7, 3'd6, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, 1'b0, a1, n1);
        wait_idle();
        chk("ldi_ready_after", {31'd0, op_ready}, 32'd1);
        chk("ldi_busy_after",  {31'd0, busy},     32'd0);
        chk("ldi_rf2", {16'd0, rf[2]}, 32'h0000BEEF);

        // ADD wraps modulo 2^16.
        send(3'd5, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, a1, n1);
        send(3'd5, 3'd1, 3'd0, 3'd0, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b0, a1, n1);
        send(3'd0, 3'd3, 3'd0, 3'd1, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, a1, n1);
        wait_idle();
        chk("add_rf3", {16'd0, rf[3]}, 32'h00000001);

        // SUB to zero, XOR, then MOV readback.
        send(3'd5, 3'd0, 3'd0, 3'd0, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b0, a1, n1);
        send(3'd5, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b0, a1, n1);
        send(3'd1, 3'd2, 3'd0, 3'd1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, a1, n1);
        send(3'd4, 3'd3, 3'd2, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b0, a1, n1);
        send(3'd6, 3'd1, 3'd3, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b0, a1, n1);
        wait_idle();
        chk("sub_rf2", {16'd0, rf[2]}, 32'h00000000);
        chk("mov_rf1", {16'd0, rf[1]}, 32'h00000005);

        // Illegal addresses and NOP behaviour; AND/OR on legal operands.
        send(3'd0, 3'd3, 3'd6, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, a1, n1);
        send(3'd7, 3'd0, 3'd7, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, a1, n1);
        send(3'd5, 3'd0, 3'd7, 3'd7, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, a1, n1);
        send(3'd2, 3'd2, 3'd0, 3'd3, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b0, a1, n1);
        send(3'd3, 3'd2, 3'd0, 3'd3, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, a1, n1);
        send(3'd2, 3'd4, 3'd0, 3'd3, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, a1, n1);
        send(3'd6, 3'd0, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, a1, n1);
        send(3'd6, 3'd1, 3'd0, 3'd7, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, a1, n1);
        wait_idle();
        chk("illegal_rf3_kept", {16'd0, rf[3]}, 32'h00000005);
        chk("or_rf2", {16'd0, rf[2]}, 32'h00001235);
        chk("mov_rf1_b", {16'd0, rf[1]}, 32'h00001234);

        // Reset mid-EXEC aborts an LDI to r2 with no write.
        op_code = 3'd5; op_rd = 3'd2; op_rs1 = 3'd0; op_rs2 = 3'd0; op_imm = 16'hAAAA;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_write", {31'd0, write},    32'd0);
        chk("rstmid_busy",  {31'd0, busy},     32'd0);
        chk("rstmid_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_rf2", {16'd0, rf[2]}, 32'h00001235);

        // Back-to-back with op_valid held high.
        send(3'd5, 3'd0, 3'd0, 3'd0, 16'h1111, 1'b1, 1'b0, 16'h1111, 1'b1, a1, n1);
        send(3'd5, 3'd1, 3'd0, 3'd0, 16'h2222, 1'b1, 1'b0, 16'h2222, 1'b0, a2, n2);
        chk("b2b_spacing", a2 - a1, 32'd4);
        chk("b2b_not_ready", n2, 32'd3);
        wait_idle();
        chk("b2b_rf0", {16'd0, rf[0]}, 32'h00001111);
        chk("b2b_rf1", {16'd0, rf[1]}, 32'h00002222);

        repeat (3) @(posedge clk);
        #1;
        tests = tests + m_tests;
        fails = fails + m_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
